// File: rtl/cfg_loader_pkg.sv
// Shared state encoding and sizing helpers for the serial config-chain loader.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CRST,
    FETCH,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } cfg_state_t;

  localparam int DEF_CHAIN_LEN = 12;
  localparam int DEF_WORD_W    = 8;
  localparam int CRST_CYCLES   = 2;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Width able to hold every value 0..n.
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int NWORDS = ceil_div(DEF_CHAIN_LEN, DEF_WORD_W);
  localparam int IDX_W  = idx_w(DEF_CHAIN_LEN);

endpackage

// File: rtl/cfg_word_serializer.sv
// Word-wide shift register presenting one bit at a time, LSB first.
// Latency: cur_bit holds word bit 0 the cycle after load; advances one bit per shift strobe.
// Backpressure: none; the owner strobes load only when it is ready for a new word.
module cfg_word_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] word,
  output logic              cur_bit
);

  logic [WORD_W-1:0] sr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= word;
    end else if (shift) begin
      sr_q <= sr_q >> 1;
    end
  end

  assign cur_bit = sr_q[0];

endmodule

// File: rtl/cfg_chain_loader.sv
// Programs a PE serial config chain from a word stream; CFG_CHAIN_READBACK_EN adds a verify pass.
// Latency: done 3 + 2*CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) cycles after start (+2*CHAIN_LEN with readback).
// Backpressure: wr_ready only in FETCH; a low wr_valid stalls with cfg_clk low, one cycle per idle cycle.
module cfg_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int WORD_W    = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WORD_W-1:0] wr_data,
  output logic              cfg_clk,
  output logic              cfg_rst,
  output logic              cfg_dout,
  input  logic              cfg_din
);

  localparam int KW = idx_w(CHAIN_LEN);
  localparam int BW = idx_w(WORD_W);

  cfg_state_t    state_q, state_d;
  logic [KW-1:0] k_q;
  logic [BW-1:0] wbit_q;
  logic [1:0]    crst_q;
  logic          cfg_clk_q, cfg_rst_q;
  logic          sr_load, sr_shift, ser_bit, out_bit, pass2_q;
  logic          start_acc, k_last, wbit_last;

  assign start_acc = (state_q == IDLE) && start;
  assign k_last    = (k_q == KW'(CHAIN_LEN - 1));
  assign wbit_last = (wbit_q == BW'(WORD_W - 1));

  cfg_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk     (clk),
    .reset   (reset),
    .load    (sr_load),
    .shift   (sr_shift),
    .word    (wr_data),
    .cur_bit (ser_bit)
  );

`ifdef CFG_CHAIN_READBACK_EN
  localparam bit READBACK = 1'b1;
  logic [CHAIN_LEN-1:0] shadow_q;
  logic                 err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass2_q  <= 1'b0;
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (start_acc) begin
        pass2_q <= 1'b0;
        err_q   <= 1'b0;
      end else if (state_q == SHIFT_HI && k_last) begin
        pass2_q <= !pass2_q;
      end
      if (state_q == SHIFT_HI && !pass2_q) shadow_q[k_q] <= ser_bit;
      // Chain output is settled while cfg_clk is low, just before rising edge k.
      if (state_q == SHIFT_LO && pass2_q && (cfg_din != shadow_q[k_q])) err_q <= 1'b1;
    end
  end

  assign out_bit = pass2_q ? shadow_q[k_q] : ser_bit;
  assign err     = err_q;
`else
  localparam bit READBACK = 1'b0;
  logic unused_din;

  assign pass2_q    = 1'b0;
  assign out_bit    = ser_bit;
  assign err        = 1'b0;
  assign unused_din = cfg_din;
`endif

  always_comb begin
    state_d  = state_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    case (state_q)
      IDLE:     if (start) state_d = CRST;
      CRST:     if (crst_q == 2'(CRST_CYCLES - 1)) state_d = FETCH;
      FETCH: begin
        if (wr_valid) begin
          sr_load = 1'b1;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: state_d = SHIFT_HI;
      SHIFT_HI: begin
        sr_shift = !pass2_q;
        if (k_last)                     state_d = (READBACK && !pass2_q) ? SHIFT_LO : DONE;
        else if (wbit_last && !pass2_q) state_d = FETCH;
        else                            state_d = SHIFT_LO;
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      wbit_q    <= '0;
      crst_q    <= '0;
      cfg_clk_q <= 1'b0;
      cfg_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cfg_clk_q <= (state_d == SHIFT_HI);
      cfg_rst_q <= (state_d == CRST);
      crst_q    <= (state_q == CRST) ? crst_q + 2'd1 : 2'd0;
      if (start_acc)               k_q <= '0;
      else if (state_q == SHIFT_HI) k_q <= k_last ? '0 : k_q + 1'b1;
      if (sr_load)                 wbit_q <= '0;
      else if (state_q == SHIFT_HI) wbit_q <= wbit_q + 1'b1;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign wr_ready = (state_q == FETCH);
  assign cfg_clk  = cfg_clk_q;
  assign cfg_rst  = cfg_rst_q;
  assign cfg_dout = (state_q == SHIFT_LO || state_q == SHIFT_HI) ? out_bit : 1'b0;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Scoreboard bench for cfg_chain_loader: a behavioural chain model captures cfg_dout on cfg_clk,
// expectations are queued at start and checked by a monitor whenever done pulses.
module tb_cfg_chain_loader;

  localparam int CHAIN_LEN = 12;
  localparam int WORD_W    = 8;
`ifdef CFG_CHAIN_READBACK_EN
  localparam int DONE_LAT  = 53;
  localparam int EDGES     = 24;
  localparam int RB        = 1;
`else
  localparam int DONE_LAT  = 29;
  localparam int EDGES     = 12;
  localparam int RB        = 0;
`endif
  // Stream 1,0,1,0,0,1,0,1,1,1,0,0 with bit 0 at the far end (chain[11]).
  localparam int CHAIN_EXP = 'hA5C;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              wr_valid = 1'b0;
  logic [WORD_W-1:0] wr_data = '0;
  logic              busy, done, err, wr_ready, cfg_clk, cfg_rst, cfg_dout, cfg_din;

  logic [CHAIN_LEN-1:0] chain;
  logic                 stuck_en = 1'b0;
  int cyc = 0, xfer_cnt = 0, edge_cnt = 0, n_vec = 0, n_bad = 0;

  typedef struct packed {
    int done_cyc;
    int err;
    int xfers;
    int edges;
    int chk_chain;
  } exp_t;

  exp_t  exp_q[$];
  string chk_nm_q[$];
  int    chk_act_q[$];
  int    chk_exp_q[$];
  string m_nm;
  int    m_act, m_exp;
  exp_t  m_x;

  cfg_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .cfg_clk  (cfg_clk),
    .cfg_rst  (cfg_rst),
    .cfg_dout (cfg_dout),
    .cfg_din  (cfg_din)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Chain model; optional stuck-at-1 on the cell that ends holding stream bit 4.
  always @(posedge cfg_clk or posedge cfg_rst) begin
    if (cfg_rst) begin
      chain <= '0;
    end else begin
      chain    <= {chain[CHAIN_LEN-2:0], cfg_dout} | (stuck_en ? 12'h080 : 12'h000);
      edge_cnt <= edge_cnt + 1;
    end
  end
  assign cfg_din = chain[CHAIN_LEN-1];

  always @(negedge clk) if (reset && wr_valid && wr_ready) xfer_cnt <= xfer_cnt + 1;

  task automatic compare(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (chk_nm_q.size() != 0) begin
      m_nm  = chk_nm_q.pop_front();
      m_act = chk_act_q.pop_front();
      m_exp = chk_exp_q.pop_front();
      compare(m_nm, m_act, m_exp);
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        compare("spurious_done", 1, 0);
      end else begin
        m_x = exp_q.pop_front();
        compare("done_cycle", cyc, m_x.done_cyc);
        compare("err_at_done", int'(err), m_x.err);
        compare("word_transfers", xfer_cnt, m_x.xfers);
        compare("cfg_clk_edges", edge_cnt, m_x.edges);
        if (m_x.chk_chain != 0) compare("chain_contents", int'(chain), CHAIN_EXP);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_chk(input string nm, input int act, input int expv);
    chk_nm_q.push_back(nm);
    chk_act_q.push_back(act);
    chk_exp_q.push_back(expv);
  endtask

  task automatic check_reset_outputs(input string tag);
    push_chk({tag, "_busy"},     int'(busy),     0);
    push_chk({tag, "_done"},     int'(done),     0);
    push_chk({tag, "_wr_ready"}, int'(wr_ready), 0);
    push_chk({tag, "_cfg_clk"},  int'(cfg_clk),  0);
    push_chk({tag, "_cfg_dout"}, int'(cfg_dout), 0);
    push_chk({tag, "_cfg_rst"},  int'(cfg_rst),  1);
    push_chk({tag, "_err"},      int'(err),      0);
  endtask

  // One load of words 0xA5, 0x03 starting in the current cycle.
  task automatic load(input int stall, input bit busy_pulse, input bit abort,
                      input int exp_err, input int chk_chain);
    int   c0;
    int   guard;
    exp_t x;
    c0 = cyc;
    push_chk("busy_before_start", int'(busy), 0);
    if (!abort) begin
      x.done_cyc  = c0 + DONE_LAT + stall;
      x.err       = exp_err;
      x.xfers     = xfer_cnt + 2;
      x.edges     = edge_cnt + EDGES;
      x.chk_chain = chk_chain;
      exp_q.push_back(x);
    end
    start    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    tick();
    start = 1'b0;
    push_chk("busy_after_start", int'(busy), 1);
    push_chk("err_cleared_on_start", int'(err), 0);
    while (cyc < c0 + 4) tick();
    wr_data = 8'h03;
    if (busy_pulse) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    if (abort) begin
      while (cyc < c0 + 17) tick();
      push_chk("cfg_clk_high_bit6", int'(cfg_clk), 1);
      reset = 1'b0;
      #1;
      check_reset_outputs("midshift_rst");
      tick();
      tick();
      push_chk("cfg_rst_held_low_reset", int'(cfg_rst), 1);
      reset = 1'b1;
      tick();
      push_chk("cfg_rst_idle_after_release", int'(cfg_rst), 0);
      push_chk("busy_idle_after_release", int'(busy), 0);
    end else begin
      if (stall > 0) begin
        while (cyc < c0 + 20) tick();
        wr_valid = 1'b0;
        for (int i = 0; i < stall; i++) begin
          @(negedge clk);
          push_chk("cfg_clk_low_in_stall", int'(cfg_clk), 0);
          push_chk("wr_ready_in_stall", int'(wr_ready), 1);
          tick();
        end
        wr_valid = 1'b1;
      end
      guard = 0;
      while (exp_q.size() != 0 && guard < 300) begin
        tick();
        guard++;
      end
      if (guard >= 300) push_chk("done_timeout", 0, 1);
    end
  endtask

  initial begin
    repeat (3) tick();
    check_reset_outputs("por");
    reset = 1'b1;
    tick();
    push_chk("cfg_rst_after_release", int'(cfg_rst), 0);
    repeat (2) tick();

    load(0, 1'b0, 1'b0, 0, 1);   // basic load
    repeat (3) tick();
    load(5, 1'b0, 1'b0, 0, 1);   // five-cycle source stall before word 2
    repeat (2) tick();
    load(0, 1'b1, 1'b0, 0, 1);   // start pulsed during SHIFT_LO
    repeat (2) tick();
    stuck_en = 1'b1;
    load(0, 1'b0, 1'b0, RB, 0);  // stuck cell
    stuck_en = 1'b0;
    load(0, 1'b0, 1'b0, 0, 1);   // back-to-back start, err must clear
    repeat (2) tick();
    load(0, 1'b0, 1'b1, 0, 0);   // reset during SHIFT_HI of bit 6
    repeat (2) tick();
    load(0, 1'b0, 1'b0, 0, 1);   // full reload after reset

    push_chk("pending_expectations", exp_q.size(), 0);
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

endmodule
